shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle shift controller around a single-bit shift stage.
//  - Loads a WIDTH-bit word and applies one 1-bit shift per clock until the requested amount is reached.
//  - Supported operations: SLL, SRL, ROL, ROR.
//  - Drives the stage's 2-bit control code h (00 hold, 01 left, 10 right, 11 clear) and its fill inputs il and ir.
//  - Sits between the ALU control path and the datapath register file as the sole sequencer of the shift stage.
// PARAMETERS
//  WIDTH  4  data word width in bits; must be >= 2
//  CNT_W  3  width of the shift-amount field; max amount is 2**CNT_W-1
// PORTS
//  clk       in   1      system clock; all state updates on rising edge
//  rst       in   1      synchronous reset, active-high
//  start     in   1      launch request; sampled only in IDLE
//  op        in   2      00 SLL, 01 SRL, 10 ROL, 11 ROR; captured on start
//  amount    in   CNT_W  number of 1-bit shifts; captured on start
//  data_in   in   WIDTH  operand; captured on start
//  clr       in   1      in IDLE only, zero the data register
//  abort     in   1      cancel the operation in progress
//  data_out  out  WIDTH  working register; shows intermediate values while busy
//  carry_out out  1      last bit shifted or rotated out
//  busy      out  1      high in SHIFT state
//  done      out  1      one-cycle pulse in DONE state
// BEHAVIOUR
//  Reset: state=IDLE; data_out, carry_out, busy, done and the internal counter are all 0.
//  FSM states and transitions:
//   - IDLE -> SHIFT on start & !abort & amount!=0.
//   - IDLE -> DONE on start & !abort & amount==0.
//   - SHIFT -> DONE on the edge where cnt==1.
//   - SHIFT -> IDLE on abort.
//   - DONE -> IDLE unconditionally.
//  Capture on start edge: data_reg<=data_in, op_reg<=op, cnt<=amount, carry_out<=0.
//  Each SHIFT edge performs exactly one 1-bit shift through the stage, then cnt<=cnt-1.
//  Stage drive per op:
//   - SLL: h=01, il=0.
//   - SRL: h=10, ir=0.
//   - ROL: h=01, il=data_reg[WIDTH-1].
//   - ROR: h=10, ir=data_reg[0].
//  Carry per shift:
//   - Left ops: carry_out<=data_reg[WIDTH-1].
//   - Right ops: carry_out<=data_reg[0].
//  Stage is driven with h=00 (hold) in DONE, and in IDLE unless clr is asserted.
//  clr in IDLE: h=11, data_reg<=0, carry_out unchanged. If start and clr are both high, start wins and clr is ignored.
//  Latency: done is high in cycle amount+1 after the start edge. amount=0 gives done in the next cycle with data unchanged.
//  amount >= WIDTH is legal:
//   - SLL/SRL yield 0.
//   - ROL/ROR by WIDTH returns the original operand.
//  start while busy or in DONE: ignored, no queuing.
//  abort in SHIFT: return to IDLE without a done pulse; data_out and carry_out keep their partial values.
//  abort in IDLE: blocks a same-cycle start.
//  rst mid-operation: immediate return to reset values, no done pulse.
//  busy and done are decoded from the state register, so they are glitch-free and never high together.
// STRUCTURE
//  Package shift_seq_pkg:
//   - shift_op_e (SLL, SRL, ROL, ROR)
//   - seq_state_e (IDLE, SHIFT, DONE)
//   - localparams H_HOLD=2'b00, H_LEFT=2'b01, H_RIGHT=2'b10, H_CLEAR=2'b11
//  Sub-module shift_stage #(WIDTH):
//   - Combinational.
//   - h=00: s=f.
//   - h=01: s={f[W-2:0],il}.
//   - h=10: s={ir,f[W-1:1]}.
//   - h=11: s=0.
//  Top-level contents:
//   - FSM, counter, op/data/carry registers, stage control decode.
//   - One shift_stage instance whose s output feeds data_reg.
// TESTING
//  1. SLL 4'b1011 by 1 -> data_out=4'b0110, carry_out=1, done in cycle 2 after start.
//  2. ROR 4'b0001 by 1 -> 4'b1000, carry_out=1; ROL 4'b1001 by 4 -> 4'b1001.
//  3. SRL 4'b1011 by 4 -> 4'b0000, carry_out=1 (orig bit3), busy high exactly 4 cycles.
//  4. amount=0 with 4'b0101 -> done next cycle, data_out=4'b0101, carry_out=0.
//  5. Start SLL by 3, pulse start again on cycle 2 -> second start ignored.
//     Then abort on cycle 3 -> IDLE, no done, data_out holds the partial value.
//  6. rst asserted mid-SHIFT -> all outputs 0 next cycle.
//     Then clr in IDLE after a prior load -> data_out=0.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and stage control codes for the multi-cycle shift sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    ROL = 2'b10,
    ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } seq_state_e;

  localparam logic [1:0] H_HOLD  = 2'b00;
  localparam logic [1:0] H_LEFT  = 2'b01;
  localparam logic [1:0] H_RIGHT = 2'b10;
  localparam logic [1:0] H_CLEAR = 2'b11;

endpackage

// File: rtl/shift_sequencer_stage.sv
// Combinational single-bit shift stage: hold, shift left/right with fill bits, or clear.
import shift_seq_pkg::*;

module shift_stage #(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       h,
  input  logic [WIDTH-1:0] f,
  input  logic             il,
  input  logic             ir,
  output logic [WIDTH-1:0] s
);

  always_comb begin
    s = f;
    case (h)
      H_HOLD:  s = f;
      H_LEFT:  s = {f[WIDTH-2:0], il};
      H_RIGHT: s = {ir, f[WIDTH-1:1]};
      H_CLEAR: s = '0;
      default: s = f;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: sequences one 1-bit shift per clock through shift_stage.
import shift_seq_pkg::*;

module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clr,
  input  logic             abort,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  seq_state_e       state, state_nxt;
  shift_op_e        op_reg;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] stage_s;
  logic [CNT_W-1:0] cnt;
  logic             carry_reg;
  logic [1:0]       h;
  logic             il, ir;
  logic             launch, step, left_op;

  assign launch  = (state == IDLE) && start && !abort;
  assign step    = (state == SHIFT) && !abort;
  assign left_op = (op_reg == SLL) || (op_reg == ROL);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = (amount == '0) ? DONE : SHIFT;
      SHIFT:   if (abort) state_nxt = IDLE;
               else if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // An aborting SHIFT cycle drives hold so the partial result is frozen as-is.
  always_comb begin
    h    = H_HOLD;
    il   = 1'b0;
    ir   = 1'b0;
    busy = (state == SHIFT);
    done = (state == DONE);
    case (state)
      IDLE: if (clr && !launch) h = H_CLEAR;
      SHIFT: begin
        if (!abort) begin
          if (left_op) begin
            h  = H_LEFT;
            il = (op_reg == ROL) && data_reg[WIDTH-1];
          end else begin
            h  = H_RIGHT;
            ir = (op_reg == ROR) && data_reg[0];
          end
        end
      end
      default: h = H_HOLD;
    endcase
  end

  shift_stage #(.WIDTH(WIDTH)) u_stage (
    .h  (h),
    .f  (data_reg),
    .il (il),
    .ir (ir),
    .s  (stage_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg  <= '0;
      op_reg    <= SLL;
      cnt       <= '0;
      carry_reg <= 1'b0;
    end else if (launch) begin
      data_reg  <= data_in;
      op_reg    <= shift_op_e'(op);
      cnt       <= amount;
      carry_reg <= 1'b0;
    end else begin
      data_reg <= stage_s;
      if (step) begin
        carry_reg <= left_op ? data_reg[WIDTH-1] : data_reg[0];
        cnt       <= cnt - CNT_W'(1);
      end
    end
  end

  assign data_out  = data_reg;
  assign carry_out = carry_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer with hand-computed expectations.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [2:0] amount = '0;
  logic [3:0] data_in = '0;
  logic       clr = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] data_out;
  logic       carry_out, busy, done;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .amount(amount),
    .data_in(data_in), .clr(clr), .abort(abort), .data_out(data_out),
    .carry_out(carry_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch at a negedge, then sample each following negedge until done (bounded).
  task automatic run_op(input logic [1:0] o, input logic [2:0] a, input logic [3:0] d,
                        output int busy_cyc, output int done_cyc);
    @(negedge clk);
    op = o; amount = a; data_in = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cyc = 0;
    done_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        done_cyc = c;
        break;
      end
      if (busy) busy_cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int bc, dc, seen;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_data", data_out, 4'b0000);
    check("rst_carry", carry_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;

    run_op(2'b00, 3'd1, 4'b1011, bc, dc);
    check("sll1_data", data_out, 4'b0110);
    check("sll1_carry", carry_out, 1'b1);
    check("sll1_lat", dc, 2);
    check("sll1_busy_excl", busy, 1'b0);

    run_op(2'b11, 3'd1, 4'b0001, bc, dc);
    check("ror1_data", data_out, 4'b1000);
    check("ror1_carry", carry_out, 1'b1);
    check("ror1_lat", dc, 2);

    run_op(2'b10, 3'd4, 4'b1001, bc, dc);
    check("rol4_data", data_out, 4'b1001);
    check("rol4_carry", carry_out, 1'b1);
    check("rol4_lat", dc, 5);

    run_op(2'b01, 3'd4, 4'b1011, bc, dc);
    check("srl4_data", data_out, 4'b0000);
    check("srl4_carry", carry_out, 1'b1);
    check("srl4_busy", bc, 4);
    check("srl4_lat", dc, 5);

    run_op(2'b10, 3'd7, 4'b0110, bc, dc);
    check("rol7_data", data_out, 4'b0011);
    check("rol7_lat", dc, 8);

    run_op(2'b00, 3'd0, 4'b0101, bc, dc);
    check("amt0_data", data_out, 4'b0101);
    check("amt0_carry", carry_out, 1'b0);
    check("amt0_lat", dc, 1);
    check("amt0_busy", bc, 0);

    // SLL 0111 by 3; restart attempt in cycle 2, abort in cycle 3
    @(negedge clk);
    op = 2'b00; amount = 3'd3; data_in = 4'b0111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ab_busy1", busy, 1'b1);
    @(negedge clk);
    op = 2'b01; amount = 3'd1; data_in = 4'b0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b1;
    check("ab_partial", data_out, 4'b1100);
    check("ab_busy3", busy, 1'b1);
    @(negedge clk);
    abort = 1'b0;
    check("ab_idle", busy, 1'b0);
    check("ab_data", data_out, 4'b1100);
    check("ab_carry", carry_out, 1'b1);
    seen = 0;
    repeat (5) begin
      if (done) seen++;
      @(negedge clk);
    end
    check("ab_nodone", seen, 0);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_data", data_out, 4'b0000);
    check("clr_carry_kept", carry_out, 1'b1);

    // start and clr together: start takes priority
    op = 2'b00; amount = 3'd0; data_in = 4'b0110; start = 1'b1; clr = 1'b1;
    @(negedge clk);
    start = 1'b0; clr = 1'b0;
    check("startclr_done", done, 1'b1);
    check("startclr_data", data_out, 4'b0110);

    // abort in IDLE blocks start
    @(negedge clk);
    op = 2'b00; amount = 3'd2; data_in = 4'b1111; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("idleab_busy", busy, 1'b0);
    check("idleab_done", done, 1'b0);
    check("idleab_data", data_out, 4'b0110);

    // reset mid-SHIFT
    op = 2'b00; amount = 3'd3; data_in = 4'b1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_carry", carry_out, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_data", data_out, 4'b0000);
    check("mid_rst_carry", carry_out, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    seen = 0;
    repeat (4) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    check("mid_rst_quiet", seen, 0);

    run_op(2'b00, 3'd0, 4'b1010, bc, dc);
    check("load_data", data_out, 4'b1010);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr2_data", data_out, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
